// File: rtl/vec_pipe_pkg.sv
// Shared types and constants for the vector MEM->WB pipeline stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// lane_vec_t / wb_entry_t describe the default 16x16 configuration for users
// outside the stage; the stage itself rebuilds the entry type from its own
// parameters so it stays correct when LANES/N/RA_W are overridden.
package vec_pipe_pkg;

  localparam int LANES_DEF = 16;
  localparam int N_DEF     = 16;
  localparam int RA_W_DEF  = 4;

  typedef logic [LANES_DEF*N_DEF-1:0] lane_vec_t;

  typedef struct packed {
    lane_vec_t               result;
    logic [RA_W_DEF-1:0]     wa3;
    logic                    regwrite;
    logic [LANES_DEF-1:0]    lanemask;
  } wb_entry_t;

  // Occupancy encodings; the stage's control state is the occupancy itself.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_state_e;

endpackage

// File: rtl/vec_lane_select.sv
// Whole-vector 2:1 select between memory read data and ALU result.
// Latency: combinational.
// Backpressure: none (pure datapath).
//
// Ports: sel (1 = mem_data), mem_data / alu_data (LANES*N), result (LANES*N).
module vec_lane_select #(
  parameter int LANES = 16,
  parameter int N     = 16
) (
  input  logic               sel,
  input  logic [LANES*N-1:0] mem_data,
  input  logic [LANES*N-1:0] alu_data,
  output logic [LANES*N-1:0] result
);

  assign result = sel ? mem_data : alu_data;

endmodule

// File: rtl/vec_wb_skid_stage.sv
// MEM->WB stage with a 2-entry skid buffer (head H + skid S), lane mask carry, flush.
// Latency: 1 cycle from accept to out_valid when empty; strict FIFO order.
// Backpressure: in_ready is !S.valid from a register, so out_ready never reaches in_ready combinationally.
//
// Ports: clk, reset (sync, active-high), flush; upstream in_valid/in_ready with
// in_rd, in_alu, in_wa3, in_regwrite, in_memtoreg, in_lanemask; downstream
// out_valid/out_ready with out_result, out_wa3, out_regwrite, out_lanemask;
// status occupancy (0..2) and saturating stall_cnt.
module vec_wb_skid_stage
  import vec_pipe_pkg::*;
#(
  parameter int LANES = 16,
  parameter int N     = 16,
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_rd,
  input  logic [LANES*N-1:0] in_alu,
  input  logic [RA_W-1:0]    in_wa3,
  input  logic               in_regwrite,
  input  logic               in_memtoreg,
  input  logic [LANES-1:0]   in_lanemask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic [RA_W-1:0]    out_wa3,
  output logic               out_regwrite,
  output logic [LANES-1:0]   out_lanemask,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [LANES*N-1:0] result;
    logic [RA_W-1:0]    wa3;
    logic               regwrite;
    logic [LANES-1:0]   lanemask;
  } entry_t;

  occ_state_e         state, state_nxt;
  entry_t             h_q, s_q, in_entry;
  logic [LANES*N-1:0] in_result;
  logic               acc, deq;
  logic               ld_h_in, ld_h_s, ld_s;

  // Select on entry so each slot stores a single lane vector.
  vec_lane_select #(.LANES(LANES), .N(N)) u_sel (
    .sel      (in_memtoreg),
    .mem_data (in_rd),
    .alu_data (in_alu),
    .result   (in_result)
  );

  assign in_entry = '{result: in_result, wa3: in_wa3,
                      regwrite: in_regwrite, lanemask: in_lanemask};

  // All handshake/status outputs derive only from registered state.
  assign out_valid    = (state != ST_EMPTY);
  assign in_ready     = (state != ST_FULL);
  assign occupancy    = state;
  assign out_result   = h_q.result;
  assign out_wa3      = h_q.wa3;
  assign out_regwrite = h_q.regwrite;
  assign out_lanemask = h_q.lanemask;

  assign acc = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_h_in   = 1'b0;
    ld_h_s    = 1'b0;
    ld_s      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt = ST_ONE;
          ld_h_in   = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && deq) begin
          ld_h_in = 1'b1;
        end else if (acc) begin
          state_nxt = ST_FULL;
          ld_s      = 1'b1;
        end else if (deq) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deq) begin
          state_nxt = ST_ONE;
          ld_h_s    = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over both handshakes; the beat offered this cycle is dropped.
    if (flush) begin
      state_nxt = ST_EMPTY;
      ld_h_in   = 1'b0;
      ld_h_s    = 1'b0;
      ld_s      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      s_q <= '0;
    end else begin
      if (ld_h_in) begin
        h_q <= in_entry;
      end else if (ld_h_s) begin
        h_q <= s_q;
      end else if (state_nxt == ST_EMPTY) begin
        // Keeps out_regwrite low whenever the head is empty, so WB needs no gating.
        h_q.regwrite <= 1'b0;
      end
      if (ld_s) s_q <= in_entry;
    end
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_vec_wb_skid_stage.sv
module tb_vec_wb_skid_stage;

  localparam int LANES = 16;
  localparam int N     = 16;
  localparam int RA_W  = 4;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset, flush, in_valid, in_ready;
  logic [LANES*N-1:0] in_rd, in_alu, out_result;
  logic [RA_W-1:0]    in_wa3, out_wa3;
  logic               in_regwrite, in_memtoreg;
  logic [LANES-1:0]   in_lanemask, out_lanemask;
  logic               out_valid, out_ready, out_regwrite;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_wb_skid_stage #(.LANES(LANES), .N(N), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_alu(in_alu), .in_wa3(in_wa3),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_lanemask(in_lanemask),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wa3(out_wa3), .out_regwrite(out_regwrite), .out_lanemask(out_lanemask),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  function automatic logic [LANES*N-1:0] fill(input logic [N-1:0] v);
    logic [LANES*N-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*N +: N] = v;
    return r;
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one ALU beat for exactly one clock edge.
  task automatic push(input logic [N-1:0] v, input logic [RA_W-1:0] wa);
    in_valid    = 1'b1;
    in_memtoreg = 1'b0;
    in_alu      = fill(v);
    in_wa3      = wa;
    in_regwrite = 1'b1;
    cycle();
    in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (out_result !== '0 || out_wa3 !== '0 || out_regwrite !== 1'b0 || out_lanemask !== '0)
      begin failures++; $display("FAIL reset_fields got=%h/%h/%b/%h exp=all zero", out_result, out_wa3, out_regwrite, out_lanemask); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < LANES; i++) in_rd[i*N +: N] = 16'h1111 * i[15:0];
    in_alu      = fill(16'hDEAD);
    in_memtoreg = 1'b1;
    in_wa3      = 4'd5;
    in_regwrite = 1'b1;
    in_lanemask = 16'h00F0;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_result[3*N +: N] !== 16'h3333) begin failures++; $display("FAIL fill_lane3 got=%h exp=3333", out_result[3*N +: N]); end
    checks++; if (out_result[15*N +: N] !== 16'hFFFF) begin failures++; $display("FAIL fill_lane15 got=%h exp=ffff", out_result[15*N +: N]); end
    checks++; if (out_wa3 !== 4'd5 || out_regwrite !== 1'b1 || out_lanemask !== 16'h00F0)
      begin failures++; $display("FAIL fill_ctrl got=%0d/%b/%h exp=5/1/00f0", out_wa3, out_regwrite, out_lanemask); end
    checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL fill_occupancy got=%0d exp=1", occupancy); end
    cycle();
    checks++; if (occupancy !== 2'd0 || out_regwrite !== 1'b0)
      begin failures++; $display("FAIL fill_drain got=occ%0d rw%b exp=occ0 rw0", occupancy, out_regwrite); end
    in_lanemask = 16'hFFFF;
  endtask

  task automatic test_skid_fill();
    out_ready = 1'b0;
    push(16'hAAAA, 4'd1);
    push(16'hBBBB, 4'd2);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL skid_occupancy got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_result !== fill(16'hAAAA) || out_wa3 !== 4'd1)
      begin failures++; $display("FAIL skid_head got=%h/%0d exp=aaaa/1", out_result[N-1:0], out_wa3); end
    // Refused beat while full: nothing may change.
    push(16'hCCCC, 4'd3);
    checks++; if (occupancy !== 2'd2 || out_result !== fill(16'hAAAA))
      begin failures++; $display("FAIL skid_hold got=occ%0d %h exp=occ2 aaaa", occupancy, out_result[N-1:0]); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_result !== fill(16'hBBBB) || out_wa3 !== 4'd2 || occupancy !== 2'd1)
      begin failures++; $display("FAIL skid_second got=%h/%0d occ%0d exp=bbbb/2 occ1", out_result[N-1:0], out_wa3, occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_back got=%b exp=1", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin failures++; $display("FAIL skid_empty got=v%b occ%0d exp=v0 occ0", out_valid, occupancy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", k, in_ready); end
      push(k[15:0], k[3:0]);
      checks++; if (out_valid !== 1'b1 || out_result !== fill(k[15:0]) || out_wa3 !== k[3:0])
        begin failures++; $display("FAIL b2b_data beat=%0d got=v%b %h/%0d exp=v1 %h/%0d", k, out_valid, out_result[N-1:0], out_wa3, k, k); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL b2b_occupancy beat=%0d got=%0d exp=1", k, occupancy); end
    end
    cycle();
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(16'hAAAA, 4'd1);
    push(16'hBBBB, 4'd2);
    // Flush with a beat on offer and WB ready at the same time.
    flush       = 1'b1;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_alu      = fill(16'hDDDD);
    in_wa3      = 4'd9;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL flush_state got=occ%0d v%b exp=occ0 v0", occupancy, out_valid); end
    checks++; if (out_regwrite !== 1'b0) begin failures++; $display("FAIL flush_regwrite got=%b exp=0", out_regwrite); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=v%b exp=v0", out_valid); end
    push(16'hEEEE, 4'd7);
    checks++; if (out_result !== fill(16'hEEEE) || out_wa3 !== 4'd7)
      begin failures++; $display("FAIL flush_next got=%h/%0d exp=eeee/7", out_result[N-1:0], out_wa3); end
    cycle();
  endtask

  task automatic test_stall_counter();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    out_ready = 1'b0;
    push(16'h5555, 4'd4);
    for (int i = 0; i < 20; i++) cycle();
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_saturate got=%0d exp=15", stall_cnt); end
    cycle();
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_hold got=%0d exp=15", stall_cnt); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL stall_reset got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    push(16'hAAAA, 4'd1);
    push(16'hBBBB, 4'd2);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL midrst_pre got=%0d exp=2", occupancy); end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_alu   = fill(16'hFFFF);
    cycle();
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0)
      begin failures++; $display("FAIL midrst_ctrl got=v%b r%b occ%0d exp=v0 r1 occ0", out_valid, in_ready, occupancy); end
    checks++; if (out_result !== '0 || out_wa3 !== '0 || out_regwrite !== 1'b0 || out_lanemask !== '0)
      begin failures++; $display("FAIL midrst_fields got=%h/%h/%b/%h exp=all zero", out_result, out_wa3, out_regwrite, out_lanemask); end
    out_ready = 1'b1;
    push(16'h1234, 4'd3);
    checks++; if (out_valid !== 1'b1 || out_result !== fill(16'h1234) || out_wa3 !== 4'd3 || occupancy !== 2'd1)
      begin failures++; $display("FAIL midrst_next got=v%b %h/%0d occ%0d exp=v1 1234/3 occ1", out_valid, out_result[N-1:0], out_wa3, occupancy); end
    cycle();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin failures++; $display("FAIL midrst_alone got=v%b occ%0d exp=v0 occ0", out_valid, occupancy); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rd = '0; in_alu = '0; in_wa3 = '0; in_regwrite = 1'b0;
    in_memtoreg = 1'b0; in_lanemask = '1;
    #2;
    test_reset();
    test_fill();
    test_skid_fill();
    test_back_to_back();
    test_flush();
    test_stall_counter();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vec_wb_skid_stage.md
Name: vec_wb_skid_stage

Overview:
Parametrised MEM->WB pipeline stage for the vector datapath, replacing the fixed 16-lane load-enable register.
- Valid/ready handshake in both directions.
- 2-entry skid buffer, so an upstream stall never creates a combinational path from the WB ready signal back to MEM.
- Per-lane write mask and synchronous flush.
- Result select (memory data vs ALU result) happens on entry, so only one lane vector is stored per entry.
- Saturating stall counter for performance monitoring.

Parameters:
LANES, 16, number of vector lanes
N, 16, bits per lane
RA_W, 4, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held entries (synchronous)
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_rd  in  LANES*N  memory read data, lane i at [i*N +: N]
in_alu  in  LANES*N  ALU result, same packing
in_wa3  in  RA_W  destination register
in_regwrite  in  1  instruction writes the register file
in_memtoreg  in  1  1 = select in_rd, 0 = select in_alu
in_lanemask  in  LANES  per-lane write enable
out_valid  out  1  head entry valid
out_ready  in  1  WB consumes head this cycle
out_result  out  LANES*N  selected lane data of head entry
out_wa3  out  RA_W  head destination
out_regwrite  out  1  head regwrite, forced 0 when out_valid=0
out_lanemask  out  LANES  head lane mask
occupancy  out  2  entries held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Storage: head register H and skid register S. Each has a valid bit, result, wa3, regwrite and lanemask.
- Outputs come directly from H. All out_* and in_ready are registered; there is no combinational in->out path.
- Entry select: result = in_memtoreg ? in_rd : in_alu. The select is whole-vector, not per lane.
- in_ready = !S.valid, registered.
- acc = in_valid && in_ready; deq = out_valid && out_ready.
- States, encoded by occupancy:
  - EMPTY (0): acc -> ONE (H loaded).
  - ONE (1), acc && deq -> ONE (H reloaded).
  - ONE (1), acc && !deq -> FULL (S loaded, H holds).
  - ONE (1), !acc && deq -> EMPTY.
  - ONE (1), neither -> hold.
  - FULL (2): acc is impossible because in_ready=0. deq -> ONE (H <= S, S.valid <= 0). !deq -> hold.
- Latency: 1 cycle from acc to out_valid when EMPTY.
- Ordering: strict FIFO.
- Holding: H contents stay stable while out_valid && !out_ready.
- in_valid && !in_ready: no state change. Upstream holds its data.
- Flush:
  - Next cycle H.valid = S.valid = 0, occupancy = 0, in_ready = 1.
  - Flush overrides acc and deq in the same cycle; the incoming beat is dropped.
  - Data fields are don't-care after flush, but out_regwrite reads 0.
  - stall_cnt is not cleared by flush.
- stall_cnt: increments by 1 each cycle out_valid && !out_ready, saturates at all-ones, does not wrap.
- Reset (any cycle, including mid-operation):
  - out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
  - out_result, out_wa3, out_lanemask, out_regwrite all 0; S fields 0.
  - Reset overrides flush and handshakes.
- Lane mask is carried only. WB applies it: a lane is written only if out_regwrite && out_lanemask[i].
- Entries with regwrite=0 still occupy a slot. Stores and branches flow through for ordering.

Decomposition:
- Package vec_pipe_pkg:
  - typedef lane_vec_t (LANES*N packed).
  - typedef wb_entry_t struct {result, wa3, regwrite, lanemask}.
  - localparams OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- One natural sub-module: vec_lane_select (LANES*N 2:1 mux on memtoreg). It is reusable in the forwarding network.
- Storage and control remain in the top module.

Test Plan:
- Reset/fill: reset 1 cycle; in_valid=1, memtoreg=1, in_rd lanes=0x1111*i, wa3=5, out_ready=1 -> out_valid next cycle, out_result lane3=0x3333, out_wa3=5, occupancy=1.
- Skid fill: out_ready=0, push A (alu=0xAAAA all lanes), then B (0xBBBB) -> occupancy=2, in_ready=0, out_result=0xAAAA held. Raise out_ready -> A out, next cycle B out, in_ready=1.
- Back-to-back: out_ready=1, 8 consecutive beats with values 1..8 -> 8 outputs in order, one per cycle, occupancy stays 1, in_ready never drops.
- Flush while FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_regwrite=0; the flushed-cycle beat never appears.
- Stall counter: with CNT_W=4, hold out_valid && !out_ready for 20 cycles -> stall_cnt=15 and holds. Reset -> 0.
- Reset mid-stream with occupancy=2 -> all outputs zero next cycle, in_ready=1, and the next accepted beat appears alone.
